serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 167 ++++++++++++++++
 tb/tb_serial_subtractor.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Computes A - B over several cycles, SLICE bits per cycle, using a
//   ripple borrow held in a carry register between slices
//   (A + ~B + 1, processed from the least significant slice upward).
//   The result and flags are registered and change only when an operation
//   completes.
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   synchronous, active-high reset
//   in_valid   in   A/B carry a valid operand pair
//   in_ready   out  block is idle and can accept an operand pair
//   A, B       in   n-bit minuend / subtrahend
//   DIFF       out  A - B modulo 2^n
//   BORROW     out  unsigned borrow (A < B)
//   OVF        out  two's-complement overflow of A - B
//   ZERO       out  DIFF == 0
//   out_valid  out  DIFF and flags hold a completed result
//   out_ready  in   consumer accepts the result
module serial_subtractor #(
    parameter int n     = 32,
    parameter int SLICE = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [n-1:0] A,
    input  logic [n-1:0] B,
    output logic [n-1:0] DIFF,
    output logic         BORROW,
    output logic         OVF,
    output logic         ZERO,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam int NSL = n / SLICE;
    localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSL - 1);

    generate
        if ((n % SLICE) != 0) begin : g_width_check
            $error("serial_subtractor: n must be a multiple of SLICE");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            carry_q, carry_d;
    logic [n-1:0]    a_q, a_d;
    logic [n-1:0]    b_q, b_d;
    logic [n-1:0]    work_q, work_d;
    logic [n-1:0]    diff_q, diff_d;
    logic            borrow_q, borrow_d;
    logic            ovf_q, ovf_d;
    logic            zero_q, zero_d;

    logic [SLICE-1:0] a_sl;
    logic [SLICE-1:0] b_sl;
    logic [SLICE:0]   sum;
    logic [n-1:0]     work_nxt;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        work_d   = work_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        a_sl     = '0;
        b_sl     = '0;

        // Select the slice addressed by the counter.
        for (int k = 0; k < NSL; k++) begin
            if (cnt_q == CW'(k)) begin
                a_sl = a_q[k*SLICE +: SLICE];
                b_sl = b_q[k*SLICE +: SLICE];
            end
        end

        sum = {1'b0, a_sl} + {1'b0, ~b_sl} + {{SLICE{1'b0}}, carry_q};

        // Working register with the freshly computed slice merged in; on the
        // last slice this is the complete difference.
        work_nxt = work_q;
        for (int k = 0; k < NSL; k++) begin
            if (cnt_q == CW'(k)) begin
                work_nxt[k*SLICE +: SLICE] = sum[SLICE-1:0];
            end
        end

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = B;
                    cnt_d   = '0;
                    carry_d = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                work_d  = work_nxt;
                carry_d = sum[SLICE];
                if (cnt_q == LAST) begin
                    cnt_d    = '0;
                    state_d  = DONE;
                    diff_d   = work_nxt;
                    borrow_d = ~sum[SLICE];
                    ovf_d    = (a_q[n-1] != b_q[n-1]) & (work_nxt[n-1] != a_q[n-1]);
                    zero_d   = (work_nxt == '0);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            work_q   <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            work_q   <= work_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    // Operand latches are only read after a fresh accept, so they need no reset.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign DIFF      = diff_q;
    assign BORROW    = borrow_q;
    assign OVF       = ovf_q;
    assign ZERO      = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [31:0] DIFF;
    logic        BORROW;
    logic        OVF;
    logic        ZERO;
    logic        out_valid;
    logic        out_ready = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    serial_subtractor #(.n(32), .SLICE(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .DIFF      (DIFF),
        .BORROW    (BORROW),
        .OVF       (OVF),
        .ZERO      (ZERO),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full operation with out_ready held high; called at #1 after an edge in IDLE.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_d, input logic eb, input logic eo,
                          input logic ez);
        logic [31:0] prev;
        int lat;
        prev      = DIFF;
        A         = a;
        B         = b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        check_val({tag, "_rdy_before"}, {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        A = ~a;
        B = ~b;
        check_val({tag, "_rdy_run"}, {31'b0, in_ready}, 32'd0);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            lat++;
            if (out_valid) break;
            check_val({tag, "_hold"}, DIFF, prev);
        end
        check_val({tag, "_latency"}, lat, 32'd4);
        check_val({tag, "_diff"}, DIFF, exp_d);
        check_val({tag, "_borrow"}, {31'b0, BORROW}, {31'b0, eb});
        check_val({tag, "_ovf"}, {31'b0, OVF}, {31'b0, eo});
        check_val({tag, "_zero"}, {31'b0, ZERO}, {31'b0, ez});
        tick();
        check_val({tag, "_idle_rdy"}, {31'b0, in_ready}, 32'd1);
        check_val({tag, "_idle_vld"}, {31'b0, out_valid}, 32'd0);
        check_val({tag, "_idle_hold"}, DIFF, exp_d);
    endtask

    initial begin
        int wait_n;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_val("rst_rdy", {31'b0, in_ready}, 32'd1);
        check_val("rst_vld", {31'b0, out_valid}, 32'd0);
        check_val("rst_diff", DIFF, 32'h0);
        check_val("rst_flags", {29'b0, BORROW, OVF, ZERO}, 32'd0);

        // Directed vectors
        run_op("ripple",   32'h0000_0100, 32'h0000_0001, 32'h0000_00FF, 1'b0, 1'b0, 1'b0);
        run_op("underflow",32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        run_op("ovf_neg",  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
        run_op("ovf_pos",  32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
        run_op("equal",    32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b0, 1'b1);

        // Backpressure and ignored in_valid during RUN/DONE
        A = 32'h0000_0010;
        B = 32'h0000_0003;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        A = 32'h0000_0FFF;
        B = 32'h0000_0001;
        check_val("bp_rdy_run", {31'b0, in_ready}, 32'd0);
        wait_n = 0;
        while (!out_valid && wait_n < 20) begin
            tick();
            wait_n++;
        end
        check_val("bp_latency", wait_n, 32'd4);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("bp_vld", {31'b0, out_valid}, 32'd1);
            check_val("bp_diff", DIFF, 32'h0000_000D);
            check_val("bp_rdy_done", {31'b0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check_val("bp_idle_rdy", {31'b0, in_ready}, 32'd1);
        check_val("bp_idle_vld", {31'b0, out_valid}, 32'd0);
        check_val("bp_idle_diff", DIFF, 32'h0000_000D);

        // Reset on the second RUN edge discards the operation
        A = 32'h0000_0100;
        B = 32'h0000_0001;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("mid_rst_rdy", {31'b0, in_ready}, 32'd1);
        check_val("mid_rst_vld", {31'b0, out_valid}, 32'd0);
        check_val("mid_rst_diff", DIFF, 32'h0);
        check_val("mid_rst_flags", {29'b0, BORROW, OVF, ZERO}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("mid_rst_no_result", {31'b0, out_valid}, 32'd0);
        end
        run_op("after_rst", 32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
